// File: rtl/maf_dot_product_seq.sv
// ---------------------------------------------------------------------------
// maf_dot_product_seq
//   Upstream sequencer for a fused multiply-accumulate (MAF) datapath.
//   Computes acc = acc (+/-) a_k*b_k for k = 0..len-1 by issuing one operand
//   pair at a time to an external MAF instance. The running accumulator is
//   fed back on maf_c_o, and the MAF result is captured after the MAF's
//   fixed latency. The final accumulator is returned on result_o.
//   Operand format: {exc[1:0], sign, exponent, mantissa[size_mantissa-2:0]}.
//
// Optional feature macro: MAF_SEQ_INIT_C_EN
//   Defined   : adds c_init_i; the accumulator starts from c_init_i.
//   Undefined : no c_init_i port; the accumulator starts from zero.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   start_i           begin an operation (sampled only while idle)
//   len_i, sub_i      pair count and add/subtract mode, latched on start_i
//   in_valid_i/in_ready_o, a_number_i, b_number_i   operand stream
//   maf_a_o, maf_b_o, maf_c_o, maf_sub_o            registered MAF inputs
//   maf_result_i      MAF result
//   c_init_i          initial accumulator (MAF_SEQ_INIT_C_EN only)
//   busy_o            high whenever not idle
//   result_valid_o    one-cycle pulse qualifying result_o
//   result_o          final accumulator value (held until next operation)
// ---------------------------------------------------------------------------
module maf_dot_product_seq #(
  parameter int size_mantissa        = 24,
  parameter int size_exponent        = 8,
  parameter int size_exception_field = 2,
  parameter int size_len             = 8,
  parameter int maf_latency          = 0,
  localparam int size = size_exponent + size_mantissa + size_exception_field
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [size_len-1:0] len_i,
  input  logic                sub_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [size-1:0]     a_number_i,
  input  logic [size-1:0]     b_number_i,
  output logic [size-1:0]     maf_a_o,
  output logic [size-1:0]     maf_b_o,
  output logic [size-1:0]     maf_c_o,
  output logic                maf_sub_o,
  input  logic [size-1:0]     maf_result_i,
`ifdef MAF_SEQ_INIT_C_EN
  input  logic [size-1:0]     c_init_i,
`endif
  output logic                busy_o,
  output logic                result_valid_o,
  output logic [size-1:0]     result_o
);

  localparam int wcnt_w = (maf_latency > 1) ? $clog2(maf_latency + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [size_len-1:0] remaining_q, remaining_d;
  logic [wcnt_w-1:0]   wcnt_q, wcnt_d;
  logic                sub_q, sub_d;
  logic [size-1:0]     acc_q, acc_d;
  logic [size-1:0]     maf_a_q, maf_a_d;
  logic [size-1:0]     maf_b_q, maf_b_d;
  logic [size-1:0]     maf_c_q, maf_c_d;
  logic                maf_sub_q, maf_sub_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;
  logic                result_valid_q, result_valid_d;
  logic [size-1:0]     result_q, result_d;
  logic [size-1:0]     acc_init;

`ifdef MAF_SEQ_INIT_C_EN
  assign acc_init = c_init_i;
`else
  assign acc_init = '0;
`endif

  always_comb begin
    state_d        = state_q;
    remaining_d    = remaining_q;
    wcnt_d         = wcnt_q;
    sub_d          = sub_q;
    acc_d          = acc_q;
    maf_a_d        = maf_a_q;
    maf_b_d        = maf_b_q;
    maf_c_d        = maf_c_q;
    maf_sub_d      = maf_sub_q;
    result_d       = result_q;
    result_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          sub_d       = sub_i;
          remaining_d = len_i;
          acc_d       = acc_init;
          state_d     = (len_i != '0) ? S_ISSUE : S_DONE;
        end
      end
      S_ISSUE: begin
        // in_ready_q is high throughout ISSUE, so valid alone qualifies.
        if (in_valid_i) begin
          maf_a_d     = a_number_i;
          maf_b_d     = b_number_i;
          maf_c_d     = acc_q;
          maf_sub_d   = sub_q;
          remaining_d = remaining_q - 1'b1;
          wcnt_d      = wcnt_w'(maf_latency);
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wcnt_q != '0) begin
          wcnt_d = wcnt_q - 1'b1;
        end else begin
          acc_d   = maf_result_i;
          state_d = (remaining_q != '0) ? S_ISSUE : S_DONE;
        end
      end
      S_DONE: begin
        result_valid_d = 1'b1;
        result_d       = acc_q;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered from the next state so they line up
    // with the state they describe.
    in_ready_d = (state_d == S_ISSUE);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      remaining_q    <= '0;
      wcnt_q         <= '0;
      sub_q          <= 1'b0;
      acc_q          <= '0;
      maf_a_q        <= '0;
      maf_b_q        <= '0;
      maf_c_q        <= '0;
      maf_sub_q      <= 1'b0;
      in_ready_q     <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      result_q       <= '0;
    end else begin
      state_q        <= state_d;
      remaining_q    <= remaining_d;
      wcnt_q         <= wcnt_d;
      sub_q          <= sub_d;
      acc_q          <= acc_d;
      maf_a_q        <= maf_a_d;
      maf_b_q        <= maf_b_d;
      maf_c_q        <= maf_c_d;
      maf_sub_q      <= maf_sub_d;
      in_ready_q     <= in_ready_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
      result_q       <= result_d;
    end
  end

  assign in_ready_o     = in_ready_q;
  assign maf_a_o        = maf_a_q;
  assign maf_b_o        = maf_b_q;
  assign maf_c_o        = maf_c_q;
  assign maf_sub_o      = maf_sub_q;
  assign busy_o         = busy_q;
  assign result_valid_o = result_valid_q;
  assign result_o       = result_q;

endmodule

// File: tb/tb_maf_dot_product_seq.sv
// ---------------------------------------------------------------------------
// tb_maf_dot_product_seq
//   Bench for maf_dot_product_seq. Two instances share clk/rst: u_dut0 with a
//   combinational MAF model (maf_latency=0) and u_dut1 with a 3-stage MAF
//   model (maf_latency=3). Expected issues and results are pushed to
//   scoreboard queues as stimulus is driven and compared when observed.
//   Honours MAF_SEQ_INIT_C_EN.
// ---------------------------------------------------------------------------
module tb_maf_dot_product_seq;
  localparam int W = 34;

  localparam logic [W-1:0] ONE   = 34'h1_3F80_0000;
  localparam logic [W-1:0] TWO   = 34'h1_4000_0000;
  localparam logic [W-1:0] THREE = 34'h1_4040_0000;
  localparam logic [W-1:0] FOUR  = 34'h1_4080_0000;
  localparam logic [W-1:0] SIX   = 34'h1_40C0_0000;
  localparam logic [W-1:0] TEN   = 34'h1_4120_0000;
  localparam logic [W-1:0] HALF  = 34'h1_3F00_0000;
  localparam logic [W-1:0] NSIX  = 34'h1_C0C0_0000;
  localparam logic [W-1:0] F255  = 34'h1_437F_0000;

`ifdef MAF_SEQ_INIT_C_EN
  localparam bit init_en = 1'b1;
`else
  localparam bit init_en = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         start [2];
  logic [7:0]   len [2];
  logic         sub [2];
  logic         in_valid [2];
  logic         in_ready [2];
  logic [W-1:0] a_num [2];
  logic [W-1:0] b_num [2];
  logic [W-1:0] maf_a [2];
  logic [W-1:0] maf_b [2];
  logic [W-1:0] maf_c [2];
  logic         maf_sub [2];
  logic         busy [2];
  logic         res_valid [2];
  logic [W-1:0] result [2];
  logic [W-1:0] maf_res0, maf_res1;
  logic [W-1:0] cinit_v;

  int checks = 0;
  int failures = 0;

  // ---- behavioural MAF model (normal and zero tags only) ----
  function automatic real to_r(input logic [W-1:0] x);
    logic [63:0] d;
    logic [10:0] e;
    if (x[33:32] == 2'b00) return 0.0;
    e = 11'(x[30:23]) + 11'd896;
    d = {x[31], e, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [W-1:0] from_r(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return '0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {2'b01, d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [W-1:0] maf_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] c, input logic s);
    real p;
    p = to_r(a) * to_r(b);
    return from_r(s ? to_r(c) - p : to_r(c) + p);
  endfunction

  always_comb maf_res0 = maf_fn(maf_a[0], maf_b[0], maf_c[0], maf_sub[0]);

  logic [W-1:0] pipe1, pipe2, pipe3;
  always @(posedge clk) begin
    pipe1 <= maf_fn(maf_a[1], maf_b[1], maf_c[1], maf_sub[1]);
    pipe2 <= pipe1;
    pipe3 <= pipe2;
  end
  assign maf_res1 = pipe3;

  maf_dot_product_seq #(.maf_latency(0)) u_dut0 (
    .clk(clk), .rst(rst), .start_i(start[0]), .len_i(len[0]), .sub_i(sub[0]),
    .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
    .a_number_i(a_num[0]), .b_number_i(b_num[0]),
    .maf_a_o(maf_a[0]), .maf_b_o(maf_b[0]), .maf_c_o(maf_c[0]), .maf_sub_o(maf_sub[0]),
    .maf_result_i(maf_res0),
`ifdef MAF_SEQ_INIT_C_EN
    .c_init_i(cinit_v),
`endif
    .busy_o(busy[0]), .result_valid_o(res_valid[0]), .result_o(result[0])
  );

  maf_dot_product_seq #(.maf_latency(3)) u_dut1 (
    .clk(clk), .rst(rst), .start_i(start[1]), .len_i(len[1]), .sub_i(sub[1]),
    .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
    .a_number_i(a_num[1]), .b_number_i(b_num[1]),
    .maf_a_o(maf_a[1]), .maf_b_o(maf_b[1]), .maf_c_o(maf_c[1]), .maf_sub_o(maf_sub[1]),
    .maf_result_i(maf_res1),
`ifdef MAF_SEQ_INIT_C_EN
    .c_init_i(cinit_v),
`endif
    .busy_o(busy[1]), .result_valid_o(res_valid[1]), .result_o(result[1])
  );

  // ---- monitor: counts on posedge, samples registered outputs on negedge ----
  int cyc = 0;
  int st_cyc = 0;
  int n_issue [2];
  int n_ready [2];
  int n_res [2];
  bit iss_pend0 = 1'b0;
  int iss_cyc1 [$];
  logic [W-1:0] obs_c0 [$];
  logic         obs_sub0 [$];
  logic [W-1:0] res_v0 [$];
  logic [W-1:0] res_v1 [$];
  int res_c0 [$];
  int res_c1 [$];

  always @(clk) begin
    if (clk) begin
      cyc++;
      for (int g = 0; g < 2; g++) begin
        if (in_ready[g]) n_ready[g]++;
        if (in_ready[g] && in_valid[g]) n_issue[g]++;
      end
      if (in_ready[0] && in_valid[0]) iss_pend0 = 1'b1;
      if (in_ready[1] && in_valid[1]) iss_cyc1.push_back(cyc);
    end else begin
      if (iss_pend0) begin
        obs_c0.push_back(maf_c[0]);
        obs_sub0.push_back(maf_sub[0]);
        iss_pend0 = 1'b0;
      end
      if (res_valid[0]) begin res_v0.push_back(result[0]); res_c0.push_back(cyc); n_res[0]++; end
      if (res_valid[1]) begin res_v1.push_back(result[1]); res_c1.push_back(cyc); n_res[1]++; end
    end
  end

  // ---- scoreboard ----
  logic [W-1:0] exp_c [$];
  logic [W-1:0] exp_r0 [$];
  logic [W-1:0] exp_r1 [$];
  logic [W-1:0] pa [$];
  logic [W-1:0] pb [$];

  // ---- drivers (inputs change on negedge or 1 ns after posedge) ----
  task automatic start_op(input int d, input logic [7:0] l, input logic s);
    @(negedge clk);
    start[d] = 1'b1; len[d] = l; sub[d] = s;
    st_cyc = cyc + 1;
    @(posedge clk);
    #1 start[d] = 1'b0;
  endtask

  task automatic feed(input int d, input logic [W-1:0] a, input logic [W-1:0] b);
    int k = 0;
    @(negedge clk);
    in_valid[d] = 1'b1; a_num[d] = a; b_num[d] = b;
    while (!in_ready[d] && k < 40) begin @(negedge clk); k++; end
    if (k >= 40) begin
      checks++; failures++;
      $display("FAIL feed_timeout dut%0d: in_ready_o stayed 0 for %0d cycles, required 1", d, k);
    end
    @(posedge clk);
    #1;
  endtask

  // Drives a full operation from pa/pb; stall_after >= 0 inserts a 7-cycle
  // valid gap (with a stray start_i) before that pair.
  task automatic drive_op(input int d, input logic [7:0] l, input logic s, input int stall_after);
    real acc = init_en ? to_r(cinit_v) : 0.0;
    start_op(d, l, s);
    for (int i = 0; i < pa.size(); i++) begin
      if (i == stall_after) begin
        @(negedge clk); in_valid[d] = 1'b0; start[d] = 1'b1; len[d] = 8'd1; sub[d] = ~s;
        @(negedge clk); start[d] = 1'b0;
        repeat (5) @(negedge clk);
      end
      if (d == 0) exp_c.push_back(from_r(acc));
      acc = s ? acc - to_r(pa[i]) * to_r(pb[i]) : acc + to_r(pa[i]) * to_r(pb[i]);
      feed(d, pa[i], pb[i]);
    end
    if (pa.size() == int'(l)) begin
      if (d == 0) exp_r0.push_back(from_r(acc));
      else        exp_r1.push_back(from_r(acc));
    end
    @(negedge clk);
    in_valid[d] = 1'b0;
  endtask

  task automatic wait_res(input int d, input int n0, input int budget);
    int k = 0;
    while (n_res[d] == n0 && k < budget) begin @(posedge clk); k++; end
    if (n_res[d] == n0) begin
      checks++; failures++;
      $display("FAIL result_timeout dut%0d: no result_valid_o within %0d cycles", d, budget);
    end
  endtask

  // ---- tests ----
  task automatic test_reset;
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({busy[d], in_ready[d], res_valid[d], maf_sub[d], result[d], maf_a[d], maf_b[d], maf_c[d]} !== '0) begin
        failures++;
        $display("FAIL reset_outputs dut%0d: busy=%0b rdy=%0b rv=%0b res=%h c=%h, required all 0",
                 d, busy[d], in_ready[d], res_valid[d], result[d], maf_c[d]);
      end
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int n0 = n_res[0];
    int ib = obs_c0.size();
    int rb = res_v0.size();
    logic [W-1:0] e;
    pa = '{TWO, ONE}; pb = '{THREE, FOUR};
    drive_op(0, 8'd2, 1'b0, -1);
    wait_res(0, n0, 50);
    checks++;
    if (obs_c0.size() != ib + 2) begin
      failures++; $display("FAIL basic_issues: got %0d issues, required 2", obs_c0.size() - ib);
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++; e = exp_c.pop_front();
        if (obs_c0[ib+i] !== e) begin
          failures++; $display("FAIL basic_maf_c%0d: got %h, required %h", i, obs_c0[ib+i], e);
        end
      end
      checks++;
      if (obs_c0[ib+1] !== SIX) begin
        failures++; $display("FAIL basic_c6: got %h, required %h", obs_c0[ib+1], SIX);
      end
    end
    if (res_v0.size() > rb) begin
      checks++; e = exp_r0.pop_front();
      if (res_v0[rb] !== e) begin
        failures++; $display("FAIL basic_result_sb: got %h, required %h", res_v0[rb], e);
      end
      checks++;
      if (res_v0[rb] !== TEN) begin
        failures++; $display("FAIL basic_result: got %h, required %h", res_v0[rb], TEN);
      end
      checks++;
      if (res_c0[rb] - st_cyc != 5) begin
        failures++; $display("FAIL basic_latency: got %0d, required 5", res_c0[rb] - st_cyc);
      end
    end
    repeat (4) @(posedge clk);
    checks++;
    if (n_res[0] - n0 != 1) begin
      failures++; $display("FAIL basic_pulse_count: got %0d, required 1", n_res[0] - n0);
    end
  endtask

  task automatic test_latency3;
    int n0 = n_res[1];
    int i0 = n_issue[1];
    int r0 = n_ready[1];
    int cb = iss_cyc1.size();
    int rb = res_v1.size();
    logic [W-1:0] e;
    pa = '{ONE, TWO, THREE}; pb = '{TWO, TWO, ONE};
    drive_op(1, 8'd3, 1'b0, -1);
    wait_res(1, n0, 100);
    checks++;
    if (n_issue[1] - i0 != 3) begin
      failures++; $display("FAIL lat3_issues: got %0d, required 3", n_issue[1] - i0);
    end
    checks++;
    if (n_ready[1] - r0 != 3) begin
      failures++; $display("FAIL lat3_ready_cycles: got %0d, required 3", n_ready[1] - r0);
    end
    if (iss_cyc1.size() >= cb + 3) begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (iss_cyc1[cb+i] - iss_cyc1[cb+i-1] != 5) begin
          failures++; $display("FAIL lat3_spacing%0d: got %0d, required 5", i, iss_cyc1[cb+i] - iss_cyc1[cb+i-1]);
        end
      end
    end
    if (res_v1.size() > rb) begin
      checks++;
      if (res_c1[rb] - st_cyc != 16) begin
        failures++; $display("FAIL lat3_latency: got %0d, required 16", res_c1[rb] - st_cyc);
      end
      checks++; e = exp_r1.pop_front();
      if (res_v1[rb] !== e) begin
        failures++; $display("FAIL lat3_result: got %h, required %h", res_v1[rb], e);
      end
    end
  endtask

  task automatic test_len_zero;
    int n0 = n_res[0];
    int r0 = n_ready[0];
    int rb = res_v0.size();
    logic [W-1:0] e;
    cinit_v = ONE;
    pa = {}; pb = {};
    drive_op(0, 8'd0, 1'b0, -1);
    wait_res(0, n0, 20);
    checks++;
    if (n_ready[0] != r0) begin
      failures++; $display("FAIL len0_ready: got %0d ready cycles, required 0", n_ready[0] - r0);
    end
    if (res_v0.size() > rb) begin
      checks++; e = exp_r0.pop_front();
      if (res_v0[rb] !== e || res_v0[rb] !== (init_en ? ONE : '0)) begin
        failures++; $display("FAIL len0_result: got %h, required %h", res_v0[rb], e);
      end
      checks++;
      if (res_c0[rb] - st_cyc != 1) begin
        failures++; $display("FAIL len0_latency: got %0d, required 1", res_c0[rb] - st_cyc);
      end
    end
    cinit_v = '0;
  endtask

  task automatic test_stall;
    int n0 = n_res[0];
    int i0 = n_issue[0];
    int ib = obs_c0.size();
    int rb = res_v0.size();
    logic [W-1:0] e;
    pa = '{ONE, THREE, TWO, HALF}; pb = '{TWO, ONE, TWO, FOUR};
    drive_op(0, 8'd4, 1'b0, 1);
    wait_res(0, n0, 100);
    repeat (10) @(posedge clk);
    checks++;
    if (n_issue[0] - i0 != 4) begin
      failures++; $display("FAIL stall_issues: got %0d, required 4", n_issue[0] - i0);
    end
    checks++;
    if (n_res[0] - n0 != 1) begin
      failures++; $display("FAIL stall_results: got %0d, required 1", n_res[0] - n0);
    end
    for (int i = ib; i < obs_c0.size(); i++) begin
      checks++; e = exp_c.pop_front();
      if (obs_c0[i] !== e || obs_sub0[i] !== 1'b0) begin
        failures++; $display("FAIL stall_maf_c%0d: got %h sub=%0b, required %h sub=0", i - ib, obs_c0[i], obs_sub0[i], e);
      end
    end
    if (res_v0.size() > rb) begin
      checks++; e = exp_r0.pop_front();
      if (res_v0[rb] !== e) begin
        failures++; $display("FAIL stall_result: got %h, required %h", res_v0[rb], e);
      end
      @(negedge clk);
      checks++;
      if (result[0] !== e || maf_a[0] !== HALF || maf_b[0] !== FOUR) begin
        failures++; $display("FAIL stall_hold: result=%h a=%h b=%h, required %h %h %h", result[0], maf_a[0], maf_b[0], e, HALF, FOUR);
      end
    end
  endtask

  task automatic test_abort;
    int n0 = n_res[0];
    int ib = obs_c0.size();
    int rb;
    logic [W-1:0] e;
    start_op(0, 8'd3, 1'b0);
    exp_c.push_back('0);
    feed(0, TWO, THREE);
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({busy[0], in_ready[0], res_valid[0], maf_sub[0], result[0], maf_a[0], maf_b[0], maf_c[0]} !== '0) begin
      failures++;
      $display("FAIL abort_outputs: busy=%0b rdy=%0b rv=%0b res=%h a=%h c=%h, required all 0",
               busy[0], in_ready[0], res_valid[0], result[0], maf_a[0], maf_c[0]);
    end
    in_valid[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    checks++;
    if (n_res[0] != n0) begin
      failures++; $display("FAIL abort_no_result: got %0d results, required 0", n_res[0] - n0);
    end
    checks++; e = exp_c.pop_front();
    if (obs_c0.size() != ib + 1 || obs_c0[ib] !== e) begin
      failures++; $display("FAIL abort_issue: got %0d issues, required 1 with c=%h", obs_c0.size() - ib, e);
    end
    n0 = n_res[0]; ib = obs_c0.size(); rb = res_v0.size();
    pa = '{TWO}; pb = '{THREE};
    drive_op(0, 8'd1, 1'b0, -1);
    wait_res(0, n0, 30);
    for (int i = ib; i < obs_c0.size(); i++) begin
      checks++; e = exp_c.pop_front();
      if (obs_c0[i] !== e) begin
        failures++; $display("FAIL after_abort_maf_c: got %h, required %h", obs_c0[i], e);
      end
    end
    if (res_v0.size() > rb) begin
      checks++; e = exp_r0.pop_front();
      if (res_v0[rb] !== e || res_v0[rb] !== SIX) begin
        failures++; $display("FAIL after_abort_result: got %h, required %h", res_v0[rb], SIX);
      end
    end
  endtask

  task automatic test_sub_init;
    int n0 = n_res[0];
    int ib = obs_c0.size();
    int rb = res_v0.size();
    logic [W-1:0] e;
    cinit_v = TEN;
    pa = '{TWO}; pb = '{THREE};
    drive_op(0, 8'd1, 1'b1, -1);
    wait_res(0, n0, 30);
    checks++;
    if (obs_c0.size() != ib + 1) begin
      failures++; $display("FAIL sub_issues: got %0d, required 1", obs_c0.size() - ib);
    end else begin
      e = exp_c.pop_front();
      if (obs_sub0[ib] !== 1'b1 || obs_c0[ib] !== e || obs_c0[ib] !== (init_en ? TEN : '0)) begin
        failures++; $display("FAIL sub_issue: sub=%0b c=%h, required sub=1 c=%h", obs_sub0[ib], obs_c0[ib], e);
      end
    end
    if (res_v0.size() > rb) begin
      checks++; e = exp_r0.pop_front();
      if (res_v0[rb] !== e || res_v0[rb] !== (init_en ? FOUR : NSIX)) begin
        failures++; $display("FAIL sub_result: got %h, required %h", res_v0[rb], e);
      end
    end
    cinit_v = '0;
  endtask

  task automatic test_max_len;
    int n0 = n_res[0];
    int i0 = n_issue[0];
    int ib = obs_c0.size();
    int rb = res_v0.size();
    logic [W-1:0] e;
    pa = {}; pb = {};
    for (int i = 0; i < 255; i++) begin pa.push_back(ONE); pb.push_back(ONE); end
    drive_op(0, 8'd255, 1'b0, -1);
    wait_res(0, n0, 100);
    checks++;
    if (n_issue[0] - i0 != 255) begin
      failures++; $display("FAIL maxlen_issues: got %0d, required 255", n_issue[0] - i0);
    end
    for (int i = ib; i < obs_c0.size(); i++) begin
      e = exp_c.pop_front();
      if (obs_c0[i] !== e) begin
        checks++; failures++;
        $display("FAIL maxlen_maf_c%0d: got %h, required %h", i - ib, obs_c0[i], e);
      end
    end
    if (res_v0.size() > rb) begin
      checks++; e = exp_r0.pop_front();
      if (res_v0[rb] !== e || res_v0[rb] !== F255) begin
        failures++; $display("FAIL maxlen_result: got %h, required %h", res_v0[rb], F255);
      end
      checks++;
      if (res_c0[rb] - st_cyc != 511) begin
        failures++; $display("FAIL maxlen_latency: got %0d, required 511", res_c0[rb] - st_cyc);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; len[d] = '0; sub[d] = 1'b0; in_valid[d] = 1'b0;
      a_num[d] = '0; b_num[d] = '0;
    end
    cinit_v = '0;
    #2;
    test_reset();
    test_basic();
    test_latency3();
    test_len_zero();
    test_stall();
    test_abort();
    test_sub_init();
    test_max_len();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
